// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Sequencer that sits between the multicycle control unit and the shared
// multiply / divide functional units. It accepts one MULT or DIV request at a
// time and latches the operands. It then fires a one-cycle start pulse into the
// selected unit and stalls the control unit until that unit reports done.
// Finally it commits the unit's result into the architectural HI/LO pair.
// MTHI/MTLO moves are handled here as well. A DIV with a zero divisor is
// rejected without launching the unit. A unit that never finishes is
// abandoned after TIMEOUT_CYCLES cycles in WAIT.
//
// Optional feature (compile-time macro MULTDIV_PERF_EN):
//   When defined, two performance counters are added:
//     OpCount     - number of committed operations (wraps)
//     StallCycles - number of cycles Busy was high (saturates)
//   When undefined, neither the ports nor the counters exist.
//
// Parameters:
//   TIMEOUT_CYCLES - max cycles spent in WAIT before the op is aborted
//   CNT_W          - width of the WAIT cycle counter (2**CNT_W > TIMEOUT_CYCLES)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = reset)
//   Req          in   start request, sampled in IDLE only
//   ReqOp        in   0 = MULT, 1 = DIV
//   RegAOut[31:0] in  operand A / MTHI-MTLO data
//   RegBOut[31:0] in  operand B
//   HIWrite      in   MTHI: HI <= RegAOut (IDLE only)
//   LOWrite      in   MTLO: LO <= RegAOut (IDLE only)
//   OpA[31:0]    out  latched operand A to the units
//   OpB[31:0]    out  latched operand B to the units
//   MultCtrl     out  multiplier start pulse
//   MultDone     in   multiplier finished
//   MultHI/LO    in   multiplier result high / low word
//   DivCtrl      out  divider start pulse
//   DivDone      in   divider finished
//   DivHI/LO     in   divider remainder / quotient
//   Busy         out  stall to the control unit
//   OpDone       out  one-cycle pulse, result committed
//   DivZero      out  one-cycle pulse, DIV by zero rejected
//   Timeout      out  one-cycle pulse, unit hung, op aborted
//   HI[31:0]     out  architectural HI
//   LO[31:0]     out  architectural LO
//   OpCount[15:0]     out  (MULTDIV_PERF_EN only) committed-op counter
//   StallCycles[31:0] out  (MULTDIV_PERF_EN only) busy-cycle counter
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int TIMEOUT_CYCLES = 48,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        ReqOp,
    input  logic [31:0] RegAOut,
    input  logic [31:0] RegBOut,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic [31:0] OpA,
    output logic [31:0] OpB,
    output logic        MultCtrl,
    input  logic        MultDone,
    input  logic [31:0] MultHI,
    input  logic [31:0] MultLO,
    output logic        DivCtrl,
    input  logic        DivDone,
    input  logic [31:0] DivHI,
    input  logic [31:0] DivLO,
    output logic        Busy,
    output logic        OpDone,
    output logic        DivZero,
    output logic        Timeout,
    output logic [31:0] HI,
    output logic [31:0] LO
`ifdef MULTDIV_PERF_EN
    ,
    output logic [15:0] OpCount,
    output logic [31:0] StallCycles
`endif
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;

    // Latched operation: 0 = MULT, 1 = DIV.
    logic                op_div;
    logic [CNT_W-1:0]    wait_cnt;

    // Result captured on the Done edge, written to HI/LO one cycle later.
    logic [DATA_W-1:0]   cap_hi;
    logic [DATA_W-1:0]   cap_lo;

    // Registered one-cycle status pulses.
    logic                div_zero_q;
    logic                timeout_q;

    // Decoded control from the next-state logic.
    logic                accept;
    logic                div_zero_hit;
    logic                timeout_hit;
    logic                capture;
    logic                sel_done;
    logic                cnt_last;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        div_zero_hit = 1'b0;
        timeout_hit  = 1'b0;
        capture      = 1'b0;
        sel_done     = op_div ? DivDone : MultDone;
        // The counter is zero in the first WAIT cycle, so the value
        // TIMEOUT_CYCLES-1 marks the last cycle the unit is allowed.
        cnt_last     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

        Busy     = (state != S_IDLE);
        MultCtrl = (state == S_LAUNCH) && !op_div;
        DivCtrl  = (state == S_LAUNCH) &&  op_div;
        OpDone   = (state == S_COMMIT);
        DivZero  = div_zero_q;
        Timeout  = timeout_q;

        case (state)
            S_IDLE: begin
                if (Req) begin
                    // A zero divisor is rejected up front; the divider is
                    // never started and the control unit is never stalled.
                    if (ReqOp && (RegBOut == '0)) begin
                        div_zero_hit = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // Done from the unit that was not launched is ignored.
                // A Done in the last allowed cycle still wins over the abort.
                if (sel_done) begin
                    capture  = 1'b1;
                    state_nx = S_COMMIT;
                end else if (cnt_last) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, operand latch, wait counter, status pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_div     <= 1'b0;
            OpA        <= '0;
            OpB        <= '0;
            wait_cnt   <= '0;
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            div_zero_q <= div_zero_hit;
            timeout_q  <= timeout_hit;

            // OpA/OpB keep the last accepted operands until the next request.
            if (accept) begin
                OpA    <= RegAOut;
                OpB    <= RegBOut;
                op_div <= ReqOp;
            end

            if (state == S_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result capture (data only; its contents matter only after a Done)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_hi <= op_div ? DivHI : MultHI;
            cap_lo <= op_div ? DivLO : MultLO;
        end
    end

    // -------------------------------------------------------------------------
    // Architectural HI/LO
    // -------------------------------------------------------------------------
    // Moves are honoured only in IDLE. A move issued together with an accepted
    // request lands now and is overwritten when the operation commits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (state == S_COMMIT) begin
            HI <= cap_hi;
            LO <= cap_lo;
        end else if (state == S_IDLE) begin
            if (HIWrite) begin
                HI <= RegAOut;
            end
            if (LOWrite) begin
                LO <= RegAOut;
            end
        end
    end

`ifdef MULTDIV_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            OpCount     <= '0;
            StallCycles <= '0;
        end else begin
            if (OpDone) begin
                OpCount <= OpCount + 16'd1;
            end
            if (Busy) begin
                StallCycles <= sat_inc32(StallCycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int TO = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req, ReqOp, HIWrite, LOWrite;
    logic [31:0] RegAOut, RegBOut;
    logic [31:0] OpA, OpB;
    logic        MultCtrl, MultDone, DivCtrl, DivDone;
    logic [31:0] MultHI, MultLO, DivHI, DivLO;
    logic        Busy, OpDone, DivZero, Timeout;
    logic [31:0] HI, LO;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .Req(Req), .ReqOp(ReqOp),
        .RegAOut(RegAOut), .RegBOut(RegBOut), .HIWrite(HIWrite), .LOWrite(LOWrite),
        .OpA(OpA), .OpB(OpB),
        .MultCtrl(MultCtrl), .MultDone(MultDone), .MultHI(MultHI), .MultLO(MultLO),
        .DivCtrl(DivCtrl), .DivDone(DivDone), .DivHI(DivHI), .DivLO(DivLO),
        .Busy(Busy), .OpDone(OpDone), .DivZero(DivZero), .Timeout(Timeout),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // kind: 0 = commit, 1 = divide-by-zero reject, 2 = timeout abort
    typedef struct {
        int          kind;
        int          op;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_len;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    // Unit stub controls: delay 0 means the unit never answers.
    int mult_delay = 1;
    int div_delay  = 1;
    bit stray_div  = 0;
    bit stray_mult = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference arithmetic: signed 32x32 -> 64 multiply, signed divide
    // giving quotient in LO and remainder in HI.
    function automatic void ref_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (!op) begin
            r  = sa * sb;
            hi = r[63:32];
            lo = r[31:0];
        end else if (sb == 0) begin
            hi = '0;
            lo = '0;
        end else begin
            r  = sa / sb;
            lo = r[31:0];
            r  = sa % sb;
            hi = r[31:0];
        end
    endfunction

    // Behavioural mult/div units: answer a fixed number of cycles after start.
    initial begin
        int          ml, dl;
        logic [31:0] mh, mlo, dh, dlo;
        ml = 0; dl = 0;
        MultDone = 0; DivDone = 0;
        MultHI = '0; MultLO = '0; DivHI = '0; DivLO = '0;
        forever begin
            @(negedge clk);
            MultDone = 0; DivDone = 0;
            MultHI = $urandom; MultLO = $urandom; DivHI = $urandom; DivLO = $urandom;
            if (ml > 0) begin
                ml--;
                if (ml == 0) begin MultDone = 1; MultHI = mh; MultLO = mlo; end
            end
            if (dl > 0) begin
                dl--;
                if (dl == 0) begin DivDone = 1; DivHI = dh; DivLO = dlo; end
            end
            if (stray_div)  begin DivDone = 1;  stray_div = 0;  end
            if (stray_mult) begin MultDone = 1; stray_mult = 0; end
            if (MultCtrl) begin ml = mult_delay; ref_op(1'b0, OpA, OpB, mh, mlo); end
            if (DivCtrl)  begin dl = div_delay;  ref_op(1'b1, OpA, OpB, dh, dlo); end
        end
    end

    // Monitor: pops an expectation whenever a status pulse appears.
    initial begin
        int   run, last_run, n, act_kind;
        bit   pend, pm, pd;
        exp_t pe;
        run = 0; last_run = 0; pend = 0; pm = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0; pend = 0; pm = 0; pd = 0;
            end else begin
                if (pend) begin
                    check("commit_hi", HI, pe.hi);
                    check("commit_lo", LO, pe.lo);
                    pend = 0;
                end
                if (MultCtrl) begin
                    check("mult_start_width", pm, 0);
                    check("start_exclusive", DivCtrl, 0);
                    if (sbq.size() > 0) check("start_unit_mult", sbq[0].op, 0);
                end
                if (DivCtrl) begin
                    check("div_start_width", pd, 0);
                    if (sbq.size() > 0) begin
                        check("start_unit_div", sbq[0].op, 1);
                        check("divzero_launched", sbq[0].kind == 1, 0);
                    end
                end
                pm = MultCtrl; pd = DivCtrl;
                if (Busy) run++;
                else begin
                    if (run != 0) last_run = run;
                    run = 0;
                end
                n = int'(OpDone) + int'(DivZero) + int'(Timeout);
                if (n != 0) begin
                    check("pulse_exclusive", n, 1);
                    if (sbq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_pulse actual=%0d%0d%0d required=none",
                                 OpDone, DivZero, Timeout);
                    end else begin
                        pe = sbq.pop_front();
                        act_kind = OpDone ? 0 : (DivZero ? 1 : 2);
                        check("pulse_kind", act_kind, pe.kind);
                        if (act_kind == 0) begin
                            check("commit_busy_len", run, pe.busy_len);
                            pend = 1;
                        end else begin
                            if (act_kind == 2) check("timeout_busy_len", last_run, pe.busy_len);
                            check("reject_busy", Busy, 0);
                            check("keep_hi", HI, pe.hi);
                            check("keep_lo", LO, pe.lo);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !Busy) break;
        end
        if (k == 300) begin
            total++; bad++;
            $display("FAIL op_complete actual=pending%0d required=pending0", sbq.size());
            sbq.delete();
        end
    endtask

    // Push the model's expectation, then drive the request for one cycle.
    task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input bit mthi, input bit mtlo);
        exp_t        e;
        logic [31:0] h, l;
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
        e.op = op;
        if (op && b == 0) begin
            e.kind = 1; e.hi = m_hi; e.lo = m_lo; e.busy_len = 0;
        end else if (delay == 0) begin
            e.kind = 2; e.hi = m_hi; e.lo = m_lo; e.busy_len = TO + 1;
        end else begin
            ref_op(op, a, b, h, l);
            m_hi = h; m_lo = l;
            e.kind = 0; e.hi = h; e.lo = l; e.busy_len = delay + 2;
        end
        sbq.push_back(e);
        if (op) div_delay = delay; else mult_delay = delay;
        @(negedge clk);
        Req = 1; ReqOp = op; RegAOut = a; RegBOut = b; HIWrite = mthi; LOWrite = mtlo;
        @(negedge clk);
        Req = 0; HIWrite = 0; LOWrite = 0; RegAOut = $urandom; RegBOut = $urandom;
    endtask

    task automatic do_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input bit mthi, input bit mtlo);
        issue(op, a, b, delay, mthi, mtlo);
        wait_done();
        if (!(op && b == 0)) begin
            check("opa_hold", OpA, a);
            check("opb_hold", OpB, b);
        end
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        HIWrite = h; LOWrite = l; RegAOut = v;
        @(negedge clk);
        HIWrite = 0; LOWrite = 0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check("move_hi", HI, m_hi);
        check("move_lo", LO, m_lo);
    endtask

    initial begin
        reset = 0; Req = 0; ReqOp = 0; HIWrite = 0; LOWrite = 0;
        RegAOut = '0; RegBOut = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_opa", OpA, 0);
        check("rst_opb", OpB, 0);
        check("rst_busy", Busy, 0);
        check("rst_ctrl", {MultCtrl, DivCtrl}, 0);
        check("rst_pulses", {OpDone, DivZero, Timeout}, 0);
        reset = 1;

        do_op(0, 32'd2, 32'd3, 33, 0, 0);
        do_op(1, 32'd7, 32'd2, 32, 0, 0);
        mt(1, 0, 32'hAAAA_5555);
        do_op(1, 32'h1234_5678, 32'd0, 5, 0, 0);
        check("divzero_hi", HI, 32'hAAAA_5555);
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(0, 32'd5, 32'd6, 10, 0, 0);
        do_op(1, 32'hFFFF_FFF9, 32'd2, 1, 0, 0);

        // Reset in the middle of WAIT; the unit's late answer must be ignored.
        mult_delay = 30;
        @(negedge clk);
        Req = 1; ReqOp = 0; RegAOut = 32'd4; RegBOut = 32'd5;
        @(negedge clk);
        Req = 0;
        repeat (10) @(negedge clk);
        reset = 0;
        #1;
        m_hi = '0; m_lo = '0;
        check("midrst_hi", HI, 0);
        check("midrst_lo", LO, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_opa", OpA, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (30) @(negedge clk);
        check("midrst_no_commit_hi", HI, 0);

        // Req while busy plus a stray DivDone during a MULT.
        issue(0, 32'd9, 32'd11, 30, 0, 0);
        repeat (4) @(negedge clk);
        Req = 1; ReqOp = 1; RegAOut = 32'd100; RegBOut = 32'd7;
        repeat (3) @(negedge clk);
        Req = 0;
        stray_div = 1;
        wait_done();
        check("busy_req_opa", OpA, 32'd9);
        check("busy_req_opb", OpB, 32'd11);

        // Stray MultDone while idle, then a DIV.
        stray_mult = 1;
        repeat (2) @(negedge clk);
        do_op(1, 32'd100, 32'd7, 12, 0, 0);

        // Moves together with requests.
        do_op(0, 32'h0001_0000, 32'h0001_0000, 8, 1, 1);
        do_op(0, 32'hDEAD_BEEF, 32'd3, 0, 1, 0);
        do_op(1, 32'hCAFE_F00D, 32'd0, 3, 0, 1);

        for (int i = 0; i < 30; i++) begin
            bit          op, h, l;
            logic [31:0] a, b;
            int          d;
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if (op && $urandom_range(0, 4) == 0) b = '0;
            d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            h  = ($urandom_range(0, 4) == 0);
            l  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(op, a, b, d, h, l);
        end

        check("final_hi", HI, m_hi);
        check("final_lo", LO, m_lo);
        check("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Sequencer between the multicycle control unit and the shared mult/div functional units.
- Accepts one MULT/DIV request at a time and latches the operands.
- Launches the selected unit with a one-cycle start pulse, then stalls the control unit until the unit's done signal.
- Commits the result into the architectural HI/LO registers and handles MTHI/MTLO writes, divide-by-zero and a hung-unit timeout.

Parameters:
TIMEOUT_CYCLES, 48, max cycles spent in WAIT before abort (must exceed the slower unit's latency)
CNT_W, 6, width of the WAIT cycle counter (2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
Req  in  1  start request from control unit, sampled in IDLE only
ReqOp  in  1  0 = MULT, 1 = DIV
RegAOut  in  32  operand A / MTHI-MTLO data
RegBOut  in  32  operand B
HIWrite  in  1  MTHI: HI <= RegAOut
LOWrite  in  1  MTLO: LO <= RegAOut
OpA  out  32  latched operand A to units
OpB  out  32  latched operand B to units
MultCtrl  out  1  mult start pulse
MultDone  in  1  mult finished
MultHI  in  32  mult result high
MultLO  in  32  mult result low
DivCtrl  out  1  div start pulse
DivDone  in  1  div finished
DivHI  in  32  remainder
DivLO  in  32  quotient
Busy  out  1  stall to control unit
OpDone  out  1  one-cycle pulse, result committed
DivZero  out  1  one-cycle pulse, DIV by zero rejected
Timeout  out  1  one-cycle pulse, unit hung, op aborted
HI  out  32  architectural HI
LO  out  32  architectural LO

Behaviour:
- Reset (reset==0, async):
  - state=IDLE.
  - HI, LO, OpA, OpB, counter = 0.
  - All control/status outputs = 0.
  - Applies mid-operation too; the unit is abandoned, no commit.
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE:
  - On Req with ReqOp=1 and RegBOut==0: DivZero=1 next cycle for exactly one cycle; HI/LO unchanged; stay IDLE; Busy stays 0.
  - On any other Req: latch OpA<=RegAOut, OpB<=RegBOut and the op; go LAUNCH.
- LAUNCH (one cycle):
  - MultCtrl=1 for MULT or DivCtrl=1 for DIV, exactly one cycle; the other start stays 0.
  - Clear counter; go WAIT.
- WAIT:
  - Counter increments each cycle.
  - Selected unit's Done=1: go COMMIT, capturing that unit's HI/LO.
  - Counter reaches TIMEOUT_CYCLES first: Timeout=1 for one cycle, go IDLE, HI/LO unchanged.
  - Done of the non-selected unit is ignored.
- COMMIT (one cycle): HI/LO take the captured values at the end of the cycle; OpDone=1; go IDLE.
- Busy: 1 in LAUNCH, WAIT, COMMIT; 0 in IDLE.
- Req while Busy: ignored (control unit must hold stall).
- MultDone/DivDone asserted in IDLE or LAUNCH: ignored.
- Latency: Req sampled at edge N → start pulse in cycle N+1 → commit edge = Done-sample edge + 1. HI/LO visible one cycle after OpDone rises.
- MTHI/MTLO:
  - Honoured in IDLE only.
  - HIWrite and LOWrite together: both registers written.
  - Same cycle as an accepted Req: the move is written, then overwritten at COMMIT.
  - Ignored while Busy.
- OpA/OpB hold their value after completion until the next accepted Req.
- Pulse outputs (OpDone, DivZero, Timeout) are mutually exclusive.

Optional Feature:
MULTDIV_PERF_EN
- Defined:
  - Adds output OpCount[15:0]: increments on each OpDone, wraps 0xFFFF→0, reset 0.
  - Adds output StallCycles[31:0]: increments every cycle Busy==1, saturates at 0xFFFFFFFF, reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, release; Req MULT 2×3; unit stub raises MultDone after 33 cycles with HI=0, LO=6 → MultCtrl exactly 1 cycle, Busy high throughout, OpDone one pulse, then HI=00000000, LO=00000006, Busy=0.
- DIV 7/2, stub DivDone after 32 cycles with DivHI=1, DivLO=3 → DivCtrl single pulse, MultCtrl never 1, HI=00000001, LO=00000003.
- Req DIV with RegBOut=0 after MTHI 0xAAAA5555 → DivZero one pulse, no DivCtrl, Busy stays 0, HI=AAAA5555.
- MULT −1×−1 with MultDone never raised → Timeout pulse after 48 WAIT cycles, Busy falls, HI/LO keep prior values; a new Req is then accepted.
- Reset pulsed low during WAIT → HI=LO=0 immediately, Busy=0; a late MultDone is ignored and no OpDone is produced.
- Req asserted again while Busy, plus a stray DivDone during a MULT → second Req ignored and no commit from DivDone; only the MULT result is committed.
